// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over the
// long-latency unit, with bounded-wait starvation relief and a busy scoreboard.
module wb_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4  // legal range 1..15
) (
  input  logic        CLK,
  input  logic        RST,
  // pipeline writeback stage
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wd,
  // long-latency unit result return
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_wd,
  output logic        lu_ready,
  // long-latency issue tracking
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rd,
  // decode-stage hazard lookup
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd_chk,
  output logic        busy_rs1,
  output logic        busy_rs2,
  output logic        busy_rd,
  output logic        pipe_stall,
  // register file write port
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        WE3
);

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_LU
  } grant_e;

  grant_e      grant;
  logic        pe;
  logic        le;
  logic        starve;
  logic [3:0]  wait_cnt;
  logic [31:1] busy;
  logic [31:1] busy_next;
  logic [31:0] busy_vec;

  // Effective requests; x0 writes are never real writes.
  assign pe       = pipe_we & (pipe_rd != 5'd0) & ~pipe_stall;
  assign le       = lu_valid & (lu_rd != 5'd0);
  assign lu_ready = lu_valid & ~pe;
  assign WE3      = pe | (lu_ready & le);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    grant = GNT_NONE;
    A3    = 5'd0;
    WD3   = 32'd0;
    if (pe) begin
      grant = GNT_PIPE;
    end else if (lu_valid) begin
      grant = GNT_LU;
    end
    unique case (grant)
      GNT_PIPE: begin
        A3  = pipe_rd;
        WD3 = pipe_wd;
      end
      GNT_LU: begin
        A3  = lu_rd;
        WD3 = lu_wd;
      end
      default: ;
    endcase
  end

  // Refused on the last allowed cycle: freeze the pipeline for the next one.
  assign starve = lu_valid & ~lu_ready & (wait_cnt == WAIT_LAST);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt   <= 4'd0;
      pipe_stall <= 1'b0;
    end else begin
      if (!lu_valid || lu_ready) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      pipe_stall <= ~pipe_stall & starve;
    end
  end

  // Scoreboard next state: an issue to a register overrides its completion.
  always_comb begin
    busy_next = busy;
    for (int i = 1; i < 32; i++) begin
      if (lu_issue && (lu_issue_rd == 5'(i))) begin
        busy_next[i] = 1'b1;
      end else if (lu_ready && (lu_rd == 5'(i))) begin
        busy_next[i] = 1'b0;
      end
    end
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it takes the async reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_vec = {busy, 1'b0};
  assign busy_rs1 = busy_vec[rs1];
  assign busy_rs2 = busy_vec[rs2];
  assign busy_rd  = busy_vec[rd_chk];

endmodule
